// File: rtl/adc_capture_pkg.sv
// Shared definitions for the ADC capture path: state encoding, field widths
// and the sample sign-extension helper.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    localparam int SAMPLE_W = 12;
    localparam int HALF_W   = 6;
    localparam int WORD_W   = 32;
    localparam int EXT_W    = 16;

    function automatic logic [EXT_W-1:0] sign_extend(input logic [SAMPLE_W-1:0] s);
        return {{(EXT_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
    endfunction

endpackage

// File: rtl/adc_pair_packer_if.sv
// Write-enable/full handshake toward the upstream FIFO.
interface adc_pair_packer_if;

    logic                              fifo_full;
    logic                              fifo_wr_en;
    logic [adc_capture_pkg::WORD_W-1:0] fifo_din;

    modport master (input fifo_full, output fifo_wr_en, output fifo_din);
    modport slave  (output fifo_full, input fifo_wr_en, input fifo_din);

endinterface

// File: rtl/adc_pair_packer_fmt.sv
// Combinational sample formatter: bit ordering of the two DDR half-words,
// offset-binary to two's complement conversion and sign extension.
module adc_sample_fmt
    import adc_capture_pkg::*;
#(
    parameter bit BIT_INTERLEAVE = 1'b1,
    parameter bit OFFSET_BINARY  = 1'b1
) (
    input  logic [SAMPLE_W-1:0] i_raw,
    output logic [EXT_W-1:0]    o_sample
);

    logic [SAMPLE_W-1:0] w_ordered;
    logic [SAMPLE_W-1:0] w_twos;

    // i_raw is {dch1, dch2}; interleave puts dch1 on odd bits, dch2 on even bits
    always_comb begin
        w_ordered = {SAMPLE_W{1'b0}};
        if (BIT_INTERLEAVE == 1'b1) begin
            for (int k = 0; k < HALF_W; k++) begin
                w_ordered[2*k+1] = i_raw[HALF_W+k];
                w_ordered[2*k]   = i_raw[k];
            end
        end else begin
            w_ordered = i_raw;
        end

        if (OFFSET_BINARY == 1'b1) begin
            w_twos = {~w_ordered[SAMPLE_W-1], w_ordered[SAMPLE_W-2:0]};
        end else begin
            w_twos = w_ordered;
        end

        o_sample = sign_extend(w_twos);
    end

endmodule

// File: rtl/adc_pair_packer.sv
// Counted ADC capture: merges DDR half-words into samples, packs two samples
// per 32-bit word and writes them to the upstream FIFO without ever stalling.
module adc_pair_packer
    import adc_capture_pkg::*;
#(
    parameter bit BIT_INTERLEAVE = 1'b1,
    parameter bit OFFSET_BINARY  = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic                dco,
    input  logic                rst,
    input  logic [HALF_W-1:0]   dch1,
    input  logic [HALF_W-1:0]   dch2,
    input  logic                start,
    input  logic [CNT_W-1:0]    n_samples,
    adc_pair_packer_if.master   fifo,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    logic [SAMPLE_W-1:0] r_s_reg;
    cap_state_t          r_state;
    logic [CNT_W-1:0]    r_remaining;
    logic                r_hi;
    logic [EXT_W-1:0]    r_low;
    logic                r_wr_en;
    logic [WORD_W-1:0]   r_din;
    logic                r_busy;
    logic                r_done;
    logic                r_overflow;

    logic [EXT_W-1:0]    w_sample;
    logic                w_last;
    logic                w_issue;
    logic [WORD_W-1:0]   w_word;

    adc_sample_fmt #(
        .BIT_INTERLEAVE (BIT_INTERLEAVE),
        .OFFSET_BINARY  (OFFSET_BINARY)
    ) u_fmt (
        .i_raw    (r_s_reg),
        .o_sample (w_sample)
    );

    // Word issue: a pair completes on the high half; an odd final sample is
    // issued as a zero-padded word in the same cycle it is taken.
    always_comb begin
        w_last  = (r_remaining == CNT_W'(1));
        w_issue = 1'b0;
        w_word  = {WORD_W{1'b0}};
        if (r_state == ST_CAPTURE) begin
            if (r_hi) begin
                w_issue = 1'b1;
                w_word  = {w_sample, r_low};
            end else if (w_last) begin
                w_issue = 1'b1;
                w_word  = {{EXT_W{1'b0}}, w_sample};
            end else begin
                w_issue = 1'b0;
            end
        end else begin
            w_issue = 1'b0;
        end
    end

    // Capture FSM, packer and FIFO handshake. FLUSH is the cycle in which the
    // final word sits on the bus; DONE coincides with the done pulse.
    always_ff @(posedge dco) begin
        if (rst) begin
            r_s_reg     <= {SAMPLE_W{1'b0}};
            r_state     <= ST_IDLE;
            r_remaining <= {CNT_W{1'b0}};
            r_hi        <= 1'b0;
            r_low       <= {EXT_W{1'b0}};
            r_wr_en     <= 1'b0;
            r_din       <= {WORD_W{1'b0}};
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_s_reg <= {dch1, dch2};
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;

            if (w_issue) begin
                if (fifo.fifo_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_wr_en <= 1'b1;
                    r_din   <= w_word;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_remaining <= n_samples;
                        r_hi        <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_busy      <= 1'b1;
                        if (n_samples == {CNT_W{1'b0}}) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    r_remaining <= r_remaining - CNT_W'(1);
                    r_hi        <= ~r_hi;
                    if (!r_hi) begin
                        r_low <= w_sample;
                    end
                    if (w_last) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo.fifo_wr_en = r_wr_en;
    assign fifo.fifo_din   = r_din;
    assign busy            = r_busy;
    assign done            = r_done;
    assign overflow        = r_overflow;

endmodule

// File: tb/tb_adc_pair_packer.sv
// Self-checking bench: a cycle-indexed stimulus plan, a per-capture
// behavioural model of expected outputs, and one per-cycle compare process.
module tb_adc_pair_packer;

    localparam int NC    = 1000;
    localparam int CNT_W = 16;

    logic              dco = 1'b0;
    logic              rst;
    logic [5:0]        dch1, dch2;
    logic              start;
    logic [CNT_W-1:0]  n_samples;
    logic              busy, done, overflow;

    adc_pair_packer_if fifo_if ();

    adc_pair_packer #(
        .BIT_INTERLEAVE (1'b1),
        .OFFSET_BINARY  (1'b1),
        .CNT_W          (CNT_W)
    ) dut (
        .dco       (dco),
        .rst       (rst),
        .dch1      (dch1),
        .dch2      (dch2),
        .start     (start),
        .n_samples (n_samples),
        .fifo      (fifo_if.master),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 dco = ~dco;

    int cyc = 0;
    always @(posedge dco) cyc <= cyc + 1;

    // stimulus plan, indexed by the cycle in which the input is presented
    logic [5:0]       d1_a [NC];
    logic [5:0]       d2_a [NC];
    logic             full_a [NC];
    logic             rst_a [NC];
    logic             st_a [NC];
    logic [CNT_W-1:0] ns_a [NC];
    int               acc_t [$];
    int               acc_n [$];

    // expected outputs, indexed by the cycle in which they are observed
    logic        exp_wr [NC];
    logic [31:0] exp_din [NC];
    logic        exp_busy [NC];
    logic        exp_done [NC];
    logic        exp_ovf [NC];

    int n_chk  = 0;
    int n_fail = 0;

    // offset-binary code u (0..4095) represents the value u - 2048
    function automatic logic [15:0] ref_sample(logic [5:0] a, logic [5:0] b);
        int u;
        u = 0;
        for (int k = 0; k < 6; k++) begin
            u += int'(a[k]) << (2*k + 1);
            u += int'(b[k]) << (2*k);
        end
        return 16'(u - 2048);
    endfunction

    task automatic add_start(int t, int n);
        st_a[t] = 1'b1;
        ns_a[t] = CNT_W'(n);
        acc_t.push_back(t);
        acc_n.push_back(n);
    endtask

    task automatic model_capture(int t, int n);
        int lim, olim, dc, iss, vis;
        logic [15:0] s [$];
        logic [31:0] word;
        lim = NC;
        for (int c = t; c < NC; c++) begin
            if (rst_a[c]) begin
                lim = c + 1;
                break;
            end
        end
        olim = lim;
        foreach (acc_t[i]) begin
            if (acc_t[i] > t && acc_t[i] + 1 < olim) olim = acc_t[i] + 1;
        end
        for (int i = 0; i < n; i++) s.push_back(ref_sample(d1_a[t+i], d2_a[t+i]));
        dc = (n == 0) ? t + 1 : t + n + 2;
        for (int c = t + 1; c <= dc; c++) if (c < lim) exp_busy[c] = 1'b1;
        if (dc < lim) exp_done[dc] = 1'b1;
        for (int j = 0; j < (n + 1) / 2; j++) begin
            if (2*j + 1 < n) begin
                iss  = t + 2*j + 2;
                word = {s[2*j+1], s[2*j]};
            end else begin
                iss  = t + n;
                word = {16'h0000, s[2*j]};
            end
            vis = iss + 1;
            if (vis < lim) begin
                if (full_a[iss]) begin
                    for (int c = vis; c < olim; c++) exp_ovf[c] = 1'b1;
                end else begin
                    exp_wr[vis]  = 1'b1;
                    exp_din[vis] = word;
                end
            end
        end
    endtask

    task automatic chk(string nm, int c, logic [31:0] act, logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, expv);
        end
    endtask

    task automatic apply(int c);
        rst               = rst_a[c];
        start             = st_a[c];
        n_samples         = ns_a[c];
        dch1              = d1_a[c];
        dch2              = d2_a[c];
        fifo_if.fifo_full = full_a[c];
    endtask

    task automatic plan();
        int c0, n, t;
        for (int c = 0; c < NC; c++) begin
            d1_a[c]   = 6'($urandom);
            d2_a[c]   = 6'($urandom);
            full_a[c] = ($urandom_range(0, 3) == 0);
            rst_a[c]  = 1'b0;
            st_a[c]   = 1'b0;
            ns_a[c]   = CNT_W'($urandom);
            exp_wr[c] = 1'b0; exp_din[c] = 32'h0; exp_busy[c] = 1'b0;
            exp_done[c] = 1'b0; exp_ovf[c] = 1'b0;
        end
        for (int c = 0; c < 3; c++) rst_a[c] = 1'b1;
        for (int c = 20; c < 80; c++) full_a[c] = 1'b0;
        for (int c = 20; c < 28; c++) begin d1_a[c] = 6'h3F; d2_a[c] = 6'h00; end
        d1_a[40] = 6'h01; d2_a[40] = 6'h00;
        d1_a[41] = 6'h02; d2_a[41] = 6'h00;
        d1_a[42] = 6'h03; d2_a[42] = 6'h00;
        full_a[64] = 1'b1;
        add_start(20, 4);
        add_start(40, 3);
        add_start(60, 6);
        add_start(80, 0);
        add_start(100, 10);
        st_a[104] = 1'b1;
        st_a[110] = 1'b1;
        add_start(130, 8);
        rst_a[133] = 1'b1;
        add_start(140, 5);
        c0 = 150;
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(0, 20);
            t = c0;
            add_start(t, n);
            st_a[t + 1 + $urandom_range(0, n)] = 1'b1;
            c0 = t + ((n == 0) ? 1 : n + 2) + 1 + $urandom_range(0, 3);
        end
        foreach (acc_t[i]) model_capture(acc_t[i], acc_n[i]);
    endtask

    // per-cycle comparison against the model plus hand-computed pins
    always @(negedge dco) begin
        if (cyc >= 1 && cyc < NC) begin
            chk("wr_en", cyc, 32'(fifo_if.fifo_wr_en), 32'(exp_wr[cyc]));
            if (exp_wr[cyc]) chk("din", cyc, fifo_if.fifo_din, exp_din[cyc]);
            chk("busy", cyc, 32'(busy), 32'(exp_busy[cyc]));
            chk("done", cyc, 32'(done), 32'(exp_done[cyc]));
            chk("overflow", cyc, 32'(overflow), 32'(exp_ovf[cyc]));
            case (cyc)
                23, 25: begin
                    chk("litA_wr", cyc, 32'(fifo_if.fifo_wr_en), 32'd1);
                    chk("litA_din", cyc, fifo_if.fifo_din, 32'h02AA02AA);
                end
                24: chk("litA_gap", cyc, 32'(fifo_if.fifo_wr_en), 32'd0);
                26: chk("litA_done", cyc, 32'(done), 32'd1);
                43: chk("litB_pair", cyc, fifo_if.fifo_din, 32'hF808F802);
                44: chk("litB_flush", cyc, fifo_if.fifo_din, 32'h0000F80A);
                45: chk("litB_done", cyc, 32'(done), 32'd1);
                63, 67: chk("litC_wr", cyc, 32'(fifo_if.fifo_wr_en), 32'd1);
                65: begin
                    chk("litC_drop", cyc, 32'(fifo_if.fifo_wr_en), 32'd0);
                    chk("litC_ovf", cyc, 32'(overflow), 32'd1);
                end
                80: chk("litD_ovf_held", cyc, 32'(overflow), 32'd1);
                81: begin
                    chk("litD_ovf_clr", cyc, 32'(overflow), 32'd0);
                    chk("litD_done", cyc, 32'(done), 32'd1);
                end
                134: begin
                    chk("litF_rst_ctl", cyc,
                        32'({fifo_if.fifo_wr_en, busy, done, overflow}), 32'd0);
                    chk("litF_rst_din", cyc, fifo_if.fifo_din, 32'h0);
                end
                default: begin
                    if (cyc < 20) chk("idle_din", cyc, fifo_if.fifo_din, 32'h0);
                end
            endcase
        end
    end

    initial begin
        plan();
        apply(0);
        while (cyc < NC - 1) begin
            @(negedge dco);
            apply(cyc);
        end
        @(negedge dco);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
